// File: rtl/subtract_pkg.sv
// Shared definitions for the background-subtraction write-side feeder.
package subtract_pkg;

    localparam int PIXEL_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } feeder_state_t;

    // A counter must be at least one bit wide, even for a one-pixel frame.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/subtract_feeder_if.sv
// Upstream FIFO read ports, downstream dual-FIFO write port and frame control
// of the subtract feeder, grouped into one bundle.
interface subtract_feeder_if;

    logic                                 enable;
    logic                                 base_empty;
    logic [subtract_pkg::PIXEL_WIDTH-1:0] base_dout;
    logic                                 base_rd_en;
    logic                                 img_empty;
    logic [subtract_pkg::PIXEL_WIDTH-1:0] img_dout;
    logic                                 img_rd_en;
    logic                                 out_full_base;
    logic                                 out_full_img;
    logic                                 out_wr_en;
    logic [subtract_pkg::PIXEL_WIDTH-1:0] out_din_base;
    logic [subtract_pkg::PIXEL_WIDTH-1:0] out_din_img;
    logic                                 frame_done;
    logic                                 busy;

    modport master (
        input  enable, base_empty, base_dout, img_empty, img_dout,
               out_full_base, out_full_img,
        output base_rd_en, img_rd_en, out_wr_en, out_din_base, out_din_img,
               frame_done, busy
    );

    modport slave (
        output enable, base_empty, base_dout, img_empty, img_dout,
               out_full_base, out_full_img,
        input  base_rd_en, img_rd_en, out_wr_en, out_din_base, out_din_img,
               frame_done, busy
    );

endinterface

// File: rtl/pair_skid.sv
// One-entry register holding a base/image pixel pair until the downstream
// dual FIFO accepts it; a new pair may load in the same cycle the old one leaves.
module pair_skid
    import subtract_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [PIXEL_WIDTH-1:0] base_in,
    input  logic [PIXEL_WIDTH-1:0] img_in,
    input  logic                   out_ready,
    output logic                   valid,
    output logic [PIXEL_WIDTH-1:0] base_out,
    output logic [PIXEL_WIDTH-1:0] img_out,
    output logic                   fire,
    output logic                   ready
);

    logic                   valid_r;
    logic [PIXEL_WIDTH-1:0] base_r;
    logic [PIXEL_WIDTH-1:0] img_r;

    // Pair register: load wins over drain so back-to-back pairs flow at full rate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            base_r  <= '0;
            img_r   <= '0;
        end else if (load) begin
            valid_r <= 1'b1;
            base_r  <= base_in;
            img_r   <= img_in;
        end else if (fire) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign fire     = valid_r & out_ready;
    assign ready    = ~valid_r | fire;
    assign valid    = valid_r;
    assign base_out = base_r;
    assign img_out  = img_r;

endmodule

// File: rtl/subtract_feeder.sv
// Pairs base/live pixels from two FWFT FIFOs and writes exactly WIDTH*HEIGHT
// pairs per frame into the subtract block's dual FIFO. Optional statistics
// outputs are enabled with SUBTRACT_FEEDER_STATS_EN.
module subtract_feeder
    import subtract_pkg::*;
#(
    parameter int WIDTH  = 720,
    parameter int HEIGHT = 540
) (
    input  logic                clk,
    input  logic                rst_n,
    subtract_feeder_if.master   bus
`ifdef SUBTRACT_FEEDER_STATS_EN
    ,
    output logic [15:0]         frame_count,
    output logic [31:0]         stall_count
`endif
);

    localparam int FRAME_PIXELS = WIDTH * HEIGHT;
    localparam int CNT_W        = cnt_width(FRAME_PIXELS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIXELS - 1);

    feeder_state_t    state_r;
    feeder_state_t    next_state_s;
    logic [CNT_W-1:0] pop_cnt_r;
    logic             pop_s;
    logic             out_ready_s;
    logic             pair_valid_s;
    logic             wr_s;
    logic             skid_ready_s;

    assign out_ready_s = ~bus.out_full_base & ~bus.out_full_img;

    pair_skid u_pair_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (pop_s),
        .base_in   (bus.base_dout),
        .img_in    (bus.img_dout),
        .out_ready (out_ready_s),
        .valid     (pair_valid_s),
        .base_out  (bus.out_din_base),
        .img_out   (bus.out_din_img),
        .fire      (wr_s),
        .ready     (skid_ready_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and pop decision; both FIFOs are only ever popped together.
    always_comb begin
        next_state_s = state_r;
        pop_s        = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (bus.enable) begin
                    next_state_s = S_RUN;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_RUN: begin
                pop_s = ~bus.base_empty & ~bus.img_empty & skid_ready_s;
                if (pop_s && (pop_cnt_r == LAST_IDX)) begin
                    next_state_s = S_DRAIN;
                end else begin
                    next_state_s = S_RUN;
                end
            end
            S_DRAIN: begin
                if (!pair_valid_s || wr_s) begin
                    next_state_s = S_DONE;
                end else begin
                    next_state_s = S_DRAIN;
                end
            end
            S_DONE: begin
                if (bus.enable) begin
                    next_state_s = S_RUN;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    // Pairs popped in the current frame; restarts whenever a frame begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_cnt_r <= '0;
        end else if ((next_state_s == S_RUN) && (state_r != S_RUN)) begin
            pop_cnt_r <= '0;
        end else if (pop_s) begin
            pop_cnt_r <= pop_cnt_r + CNT_W'(1);
        end else begin
            pop_cnt_r <= pop_cnt_r;
        end
    end

    assign bus.base_rd_en = pop_s;
    assign bus.img_rd_en  = pop_s;
    assign bus.out_wr_en  = wr_s;
    assign bus.frame_done = (state_r == S_DONE);
    assign bus.busy       = (state_r == S_RUN) || (state_r == S_DRAIN);

`ifdef SUBTRACT_FEEDER_STATS_EN
    logic [15:0] frame_count_r;
    logic [31:0] stall_count_r;

    // Completed frames, wrapping naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count_r <= 16'd0;
        end else if (state_r == S_DONE) begin
            frame_count_r <= frame_count_r + 16'd1;
        end else begin
            frame_count_r <= frame_count_r;
        end
    end

    // Cycles a held pair waited on a full downstream FIFO, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_r <= 32'd0;
        end else if ((state_r == S_IDLE) && (next_state_s == S_RUN)) begin
            stall_count_r <= 32'd0;
        end else if (pair_valid_s && !wr_s && (stall_count_r != 32'hFFFF_FFFF)) begin
            stall_count_r <= stall_count_r + 32'd1;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign frame_count = frame_count_r;
    assign stall_count = stall_count_r;
`endif

endmodule

// File: tb/tb_subtract_feeder.sv
// Scoreboard bench for subtract_feeder with queue-modelled upstream FIFOs.
module tb_subtract_feeder;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int FP = W * H;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    subtract_feeder_if bus();

`ifdef SUBTRACT_FEEDER_STATS_EN
    logic [15:0] frame_count;
    logic [31:0] stall_count;
`endif

    subtract_feeder #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef SUBTRACT_FEEDER_STATS_EN
        ,
        .frame_count (frame_count),
        .stall_count (stall_count)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] up_base_q[$];
    logic [7:0] up_img_q[$];
    logic [7:0] exp_base_q[$];
    logic [7:0] exp_img_q[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   total_writes = 0;
    int   frames_seen = 0;
    int   wr_cnt = 0;
    int   first_wr_cyc = 0;
    int   eighth_wr_cyc = 0;
    logic done_exp = 1'b0;
    logic pop_pend = 1'b0;
    logic rand_full = 1'b0;
    logic full_base_f = 1'b0;
    logic full_img_f = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_base(input logic [7:0] b);
        up_base_q.push_back(b);
        exp_base_q.push_back(b);
    endtask

    task automatic push_img(input logic [7:0] i);
        up_img_q.push_back(i);
        exp_img_q.push_back(i);
    endtask

    task automatic refresh_drive();
        bus.base_empty = (up_base_q.size() == 0);
        bus.base_dout  = (up_base_q.size() == 0) ? 8'h00 : up_base_q[0];
        bus.img_empty  = (up_img_q.size() == 0);
        bus.img_dout   = (up_img_q.size() == 0) ? 8'h00 : up_img_q[0];
        if (rand_full) begin
            bus.out_full_base = ($urandom_range(0, 3) == 0);
            bus.out_full_img  = ($urandom_range(0, 3) == 0);
        end else begin
            bus.out_full_base = full_base_f;
            bus.out_full_img  = full_img_f;
        end
    endtask

    // Upstream FIFO model: a pop sampled before the edge retires the head after it.
    always begin
        @(posedge clk);
        #1;
        if (pop_pend) begin
            void'(up_base_q.pop_front());
            void'(up_img_q.pop_front());
        end
        pop_pend = 1'b0;
        #1;
        refresh_drive();
    end

    // Monitor: protocol rules, frame_done timing and pair ordering.
    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            check("rd_en_pair", {31'd0, bus.base_rd_en}, {31'd0, bus.img_rd_en});
            check("pop_when_empty", {31'd0, (bus.base_rd_en & bus.base_empty) | (bus.img_rd_en & bus.img_empty)}, 32'd0);
            check("wr_when_full", {31'd0, bus.out_wr_en & (bus.out_full_base | bus.out_full_img)}, 32'd0);
            check("frame_done", {31'd0, bus.frame_done}, {31'd0, done_exp});
            if (bus.frame_done) frames_seen++;
            pop_pend = bus.base_rd_en;
            done_exp = 1'b0;
            if (bus.out_wr_en) begin
                if (exp_base_q.size() == 0 || exp_img_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%0h/%0h required=none", bus.out_din_base, bus.out_din_img);
                end else begin
                    check("pair_base", {24'd0, bus.out_din_base}, {24'd0, exp_base_q.pop_front()});
                    check("pair_img", {24'd0, bus.out_din_img}, {24'd0, exp_img_q.pop_front()});
                end
                total_writes++;
                if (total_writes == 1) first_wr_cyc = cyc;
                if (total_writes == 8) eighth_wr_cyc = cyc;
                wr_cnt++;
                if (wr_cnt == FP) begin
                    wr_cnt = 0;
                    done_exp = 1'b1;
                end
            end
        end
    end

    task automatic wait_writes(input int n, input string name);
        int b = 0;
        while (total_writes < n && b < 2000) begin
            @(negedge clk);
            #1;
            b++;
        end
        check(name, total_writes, (total_writes < n) ? n : total_writes);
    endtask

    task automatic wait_frames(input int n, input string name);
        int b = 0;
        while (frames_seen < n && b < 4000) begin
            @(negedge clk);
            #1;
            b++;
        end
        check(name, frames_seen, (frames_seen < n) ? n : frames_seen);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_base_rd_en"}, {31'd0, bus.base_rd_en}, 32'd0);
        check({tag, "_img_rd_en"}, {31'd0, bus.img_rd_en}, 32'd0);
        check({tag, "_out_wr_en"}, {31'd0, bus.out_wr_en}, 32'd0);
        check({tag, "_out_din_base"}, {24'd0, bus.out_din_base}, 32'd0);
        check({tag, "_out_din_img"}, {24'd0, bus.out_din_img}, 32'd0);
        check({tag, "_frame_done"}, {31'd0, bus.frame_done}, 32'd0);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    endtask

    logic [7:0] held_base;
    logic [7:0] held_img;
    int         frames_at_reset = 0;
    int         wr_mark = 0;

    initial begin
        bus.enable = 1'b0;
        refresh_drive();
        #12;
        check_outputs_zero("reset");
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Frame 1: preloaded ramp, downstream always ready.
        for (int k = 0; k < FP; k++) begin
            push_base(8'h10 + 8'(k));
            push_img(8'h20 + 8'(k));
        end
        bus.enable = 1'b1;
        wait_writes(8, "frame1_writes");
        check("frame1_back_to_back", eighth_wr_cyc - first_wr_cyc, 32'd7);
        wait_frames(1, "frame1_done");

        // Image data without base data must not pop either side.
        for (int k = 0; k < 4; k++) push_img(8'h80 + 8'(k));
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("img_untouched", up_img_q.size(), 32'd4);
        check("no_write_one_sided", total_writes, 32'd8);
        check("busy_in_run", {31'd0, bus.busy}, 32'd1);
        for (int k = 0; k < FP; k++) push_base(8'h90 + 8'(k));
        for (int k = 4; k < FP; k++) push_img(8'h80 + 8'(k));

        // Downstream image side full for 5 cycles mid-frame.
        wait_writes(11, "stall_prelude");
        @(posedge clk);
        #1;
        full_img_f = 1'b1;
        @(negedge clk);
        held_base = bus.out_din_base;
        held_img  = bus.out_din_img;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("stall_no_wr", {31'd0, bus.out_wr_en}, 32'd0);
            check("stall_no_pop", {31'd0, bus.base_rd_en}, 32'd0);
            check("stall_hold_base", {24'd0, bus.out_din_base}, {24'd0, held_base});
            check("stall_hold_img", {24'd0, bus.out_din_img}, {24'd0, held_img});
        end
        @(posedge clk);
        #1;
        full_img_f = 1'b0;
        wait_frames(2, "frame2_done");
        check("frame2_writes", total_writes, 32'd16);

        // Enable drops at pixel 3: the frame still finishes, nothing more is popped.
        for (int k = 0; k < 2 * FP; k++) begin
            push_base(8'hA0 + 8'(k));
            push_img(8'hC0 + 8'(k));
        end
        wait_writes(19, "enable_drop_prelude");
        bus.enable = 1'b0;
        wait_frames(3, "frame3_done");
        repeat (5) @(negedge clk);
        check("idle_not_busy", {31'd0, bus.busy}, 32'd0);
        check("no_ninth_pop", up_base_q.size(), 32'd8);
        check("frame3_writes", total_writes, 32'd24);

        // Reset during pixel 5 of the next frame.
        bus.enable = 1'b1;
        wait_writes(29, "reset_prelude");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        up_base_q.delete();
        up_img_q.delete();
        exp_base_q.delete();
        exp_img_q.delete();
        pop_pend = 1'b0;
        done_exp = 1'b0;
        wr_cnt = 0;
        frames_at_reset = frames_seen;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        wr_mark = total_writes;
        for (int k = 0; k < FP; k++) begin
            push_base(8'h40 + 8'(k));
            push_img(8'h50 + 8'(k));
        end
        wait_frames(frames_at_reset + 1, "post_reset_frame");
        check("post_reset_writes", total_writes - wr_mark, 32'(FP));

        // Randomized traffic with random downstream back-pressure.
        rand_full = 1'b1;
        for (int k = 0; k < 4 * FP; k++) begin
            push_base(8'($urandom));
            push_img(8'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        wait_frames(frames_at_reset + 5, "random_frames");
        rand_full = 1'b0;
        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_base_q.size() + exp_img_q.size(), 32'd0);

`ifdef SUBTRACT_FEEDER_STATS_EN
        check("frame_count", {16'd0, frame_count}, 32'(frames_seen - frames_at_reset));
        check("stall_count_seen", {31'd0, stall_count != 32'd0}, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/subtract_feeder.md
# subtract_feeder

Write-side companion to the background-subtraction datapath. It drains two upstream first-word-fall-through FIFOs (base frame and live image), pairs their pixels, and drives the subtract block's dual input FIFO, whose single shared write strobe must only fire when both sides can accept. Transfers are gated per frame: exactly WIDTH*HEIGHT pairs per frame, followed by a frame_done pulse.

## Interface
- WIDTH, 720, pixels per line
- HEIGHT, 540, lines per frame
- clock  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-low; low clears all state
- enable  in  1  level; frame starts in S_IDLE when high
- base_empty  in  1  upstream base FIFO empty
- base_dout  in  8  upstream base pixel, valid while base_empty low
- base_rd_en  out  1  pop upstream base FIFO
- img_empty  in  1  upstream image FIFO empty
- img_dout  in  8  upstream image pixel, valid while img_empty low
- img_rd_en  out  1  pop upstream image FIFO
- out_full_base  in  1  downstream base FIFO full
- out_full_img  in  1  downstream image FIFO full
- out_wr_en  out  1  shared write strobe to both downstream FIFOs
- out_din_base  out  8  base pixel to downstream
- out_din_img  out  8  image pixel to downstream
- frame_done  out  1  one-cycle pulse after last pair of a frame is written
- busy  out  1  high in S_RUN and S_DRAIN

## Operation
- One-entry pair register (pair_valid, pair_base, pair_img); out_din_* driven from it.
- out_wr_en = pair_valid & !out_full_base & !out_full_img (combinational).
- pop = (state==S_RUN) & !base_empty & !img_empty & (!pair_valid | out_wr_en); base_rd_en = img_rd_en = pop. Both FIFOs always popped together; never one alone.
- On pop: pair register loads both douts, pair_valid=1. On out_wr_en without pop: pair_valid=0.
- pop_cnt: width $clog2(WIDTH*HEIGHT), increments on pop, cleared on entering S_RUN.
- States:
  - S_IDLE: no pops; -> S_RUN when enable high.
  - S_RUN: pops as above; pop with pop_cnt==WIDTH*HEIGHT-1 -> S_DRAIN.
  - S_DRAIN: no pops; when pair register empties (out_wr_en this cycle or pair_valid already 0) -> S_DONE.
  - S_DONE: frame_done=1 for this cycle; -> S_RUN if enable high (pop_cnt cleared), else S_IDLE.
- enable dropping mid-frame does not abort; the frame completes.
- Downstream full on either side stalls both; pair held unchanged, no data lost or duplicated.
- Reset mid-frame: pair discarded, pop_cnt=0, state S_IDLE.

## Timing
- Reset values: base_rd_en=0, img_rd_en=0, out_wr_en=0, out_din_base=0, out_din_img=0, frame_done=0, busy=0.
- Latency: pair popped in cycle N is written at earliest in N+1.
- Throughput: one pair per cycle sustained when upstream non-empty and downstream not full.
- frame_done asserts the cycle after the last out_wr_en of the frame; minimum frame time WIDTH*HEIGHT+2 cycles.
- Upstream FIFO contract: rd_en only while !empty; dout advances next cycle.

## Configuration
- SUBTRACT_FEEDER_STATS_EN defined: adds outputs frame_count (16 bits, increments in S_DONE, wraps at 65535->0) and stall_count (32 bits, increments each cycle pair_valid & !out_wr_en, saturates at all-ones, cleared on entering S_RUN from S_IDLE); both reset to 0.
- Undefined: neither port nor counter exists; behaviour otherwise identical.

## Structure
- Shared package subtract_pkg: state enum feeder_state_t (S_IDLE, S_RUN, S_DRAIN, S_DONE), PIXEL_WIDTH=8 constant.
- One sub-module: pair_skid (one-entry pair register with valid/accept handshake); FSM and counters in subtract_feeder.

## Test plan
- WIDTH=4, HEIGHT=2, enable=1, both upstream preloaded with 8 pixels (base 0x10..0x17, img 0x20..0x27), downstream never full -> 8 consecutive writes pairing 0x10/0x20..0x17/0x27, frame_done pulse one cycle after 8th write.
- Base FIFO empty while image has data -> no pops on either side; img FIFO contents untouched.
- out_full_img held high 5 cycles mid-frame -> out_wr_en low, pair held stable, no pops; resumes with next pair, total still 8 writes.
- enable low at pixel 3 -> frame finishes all 8 pairs, frame_done pulses, state S_IDLE, no 9th pop.
- reset low during pixel 5 -> all outputs 0 immediately; after release and enable, next frame counts from 0.
- With SUBTRACT_FEEDER_STATS_EN, two frames with one 3-cycle downstream stall -> frame_count=2, stall_count=3 (frame 2).
